// File: rtl/maze_pkg.sv
// Shared maze-solver types: move codes, packed locations, replay FSM codes.
// Optional bound checking in move_stack is enabled by MOVE_STACK_BOUNDS_CHK_EN.
package maze_pkg;

   typedef logic [1:0] dir_t;

   typedef struct packed {
      logic [3:0] x;
      logic [3:0] y;
   } loc_t;

   localparam dir_t DIR_YM = 2'b00;
   localparam dir_t DIR_XP = 2'b01;
   localparam dir_t DIR_XM = 2'b10;
   localparam dir_t DIR_YP = 2'b11;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   function automatic dir_t inv_dir(input dir_t d);
      return d ^ 2'b11;
   endfunction

endpackage

// File: rtl/move_step.sv
// One-step move arithmetic: location plus move code, modulo-16 per axis.
// wrap flags a coordinate crossing 0<->15.
module move_step
   import maze_pkg::*;
(
   input  loc_t loc,
   input  dir_t dir,
   output loc_t nextLoc,
   output logic wrap
);

   logic       selX;
   logic       inc;
   logic [3:0] coord;
   logic [3:0] moved;

   // odd parity codes move along x, dir[0] picks the sign
   assign selX  = ^dir;
   assign inc   = dir[0];
   assign coord = selX ? loc.x : loc.y;
   assign moved = inc ? coord + 4'd1 : coord - 4'd1;
   assign wrap  = inc ? (coord == 4'hf) : (coord == 4'h0);

   always_comb begin
      nextLoc = loc;
      if (selX) nextLoc.x = moved;
      else      nextLoc.y = moved;
   end

endmodule

// File: rtl/move_stack.sv
// Path memory for the maze solver: push/pop/backtrack and path replay.
// Define MOVE_STACK_BOUNDS_CHK_EN to add the sticky bnd_err output.
module move_stack
   import maze_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int AW    = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  logic [1:0] push_dir,
   input  logic       pop,
   input  logic [7:0] cur_loc,
   output logic [7:0] back_loc,
   output logic [1:0] top_dir,
   output logic       empty,
   output logic       full,
   output logic       ovf,
   input  logic       rp_start,
   input  logic [7:0] rp_origin,
   output logic [7:0] rp_loc,
   output logic       rp_valid,
   input  logic       rp_ready,
   output logic       rp_last,
   output logic       busy
`ifdef MOVE_STACK_BOUNDS_CHK_EN
   ,
   output logic       bnd_err
`endif
);

   localparam logic [AW:0] SP_ONE  = (AW+1)'(1);
   localparam logic [AW:0] SP_FULL = (AW+1)'(DEPTH);

   logic [0:0]    state;
   logic [AW:0]   sp;
   logic [AW:0]   spNext;
   logic [AW:0]   rpIndex;
   logic [AW-1:0] topIdx;
   logic [AW-1:0] wrIdx;
   logic          wrEn;
   logic          ovfSet;
   logic          dropPush;
   logic          pushBnd;
   logic          isIdle;
   logic          rpFire;

   dir_t mem [DEPTH];
   dir_t topRaw;
   dir_t invTop;
   dir_t rpDir;
   loc_t backRaw;
   loc_t rpNext;
   logic backWrap;
   logic rpWrap;
   logic unusedSink;

   assign isIdle = (state == ST_IDLE);
   assign busy   = (state == ST_RUN);
   assign empty  = (sp == '0);
   assign full   = (sp == SP_FULL);
   assign topIdx = AW'(sp - SP_ONE);
   assign topRaw = mem[topIdx];
   assign invTop = inv_dir(topRaw);
   assign rpDir  = mem[rpIndex[AW-1:0]];

   assign top_dir  = empty ? 2'b00 : topRaw;
   assign back_loc = empty ? 8'h00 : backRaw;
   assign rp_last  = rp_valid && (rpIndex == sp);
   assign rpFire   = busy && rp_valid && rp_ready;

   move_step backStep (
      .loc     (cur_loc),
      .dir     (invTop),
      .nextLoc (backRaw),
      .wrap    (backWrap)
   );

   move_step rpStep (
      .loc     (rp_loc),
      .dir     (rpDir),
      .nextLoc (rpNext),
      .wrap    (rpWrap)
   );

`ifdef MOVE_STACK_BOUNDS_CHK_EN
   loc_t unusedPushLoc;
   logic pushWrap;

   move_step pushStep (
      .loc     (cur_loc),
      .dir     (push_dir),
      .nextLoc (unusedPushLoc),
      .wrap    (pushWrap)
   );

   assign dropPush   = pushWrap;
   assign unusedSink = ^{backWrap, unusedPushLoc};
`else
   assign dropPush   = 1'b0;
   assign unusedSink = ^{backWrap, rpWrap, pushBnd};
`endif

   // push&pop on a non-empty stack rewrites the top in place
   always_comb begin
      spNext  = sp;
      wrEn    = 1'b0;
      wrIdx   = sp[AW-1:0];
      ovfSet  = 1'b0;
      pushBnd = 1'b0;
      if (isIdle) begin
         unique case (1'b1)
            push && pop && !empty: begin
               if (dropPush) begin
                  pushBnd = 1'b1;
               end else begin
                  wrEn  = 1'b1;
                  wrIdx = topIdx;
               end
            end
            push && (!pop || empty): begin
               if (full) begin
                  ovfSet = 1'b1;
               end else if (dropPush) begin
                  pushBnd = 1'b1;
               end else begin
                  wrEn   = 1'b1;
                  spNext = sp + SP_ONE;
               end
            end
            pop && !push: begin
               if (!empty) spNext = sp - SP_ONE;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wrEn) mem[wrIdx] <= push_dir;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sp       <= '0;
         state    <= ST_IDLE;
         ovf      <= 1'b0;
         rp_valid <= 1'b0;
         rp_loc   <= '0;
         rpIndex  <= '0;
      end else begin
         sp <= spNext;
         if (ovfSet) ovf <= 1'b1;
         if (isIdle) begin
            if (rp_start) begin
               state    <= ST_RUN;
               rp_loc   <= rp_origin;
               rp_valid <= 1'b1;
               rpIndex  <= '0;
            end
         end else if (rpFire) begin
            if (rp_last) begin
               rp_valid <= 1'b0;
               state    <= ST_IDLE;
            end else begin
               rp_loc  <= rpNext;
               rpIndex <= rpIndex + SP_ONE;
            end
         end
      end
   end

`ifdef MOVE_STACK_BOUNDS_CHK_EN
   // replay still emits the wrapped location, only the flag records it
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bnd_err <= 1'b0;
      end else if (pushBnd || (rpFire && !rp_last && rpWrap)) begin
         bnd_err <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_move_stack.sv
// Randomised bench for move_stack against a queue-based path model.
// Build with +define+MOVE_STACK_BOUNDS_CHK_EN to also cover bnd_err.
module tb_move_stack;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       push = 1'b0;
   logic       pop = 1'b0;
   logic [1:0] push_dir = 2'b00;
   logic [7:0] cur_loc = 8'h00;
   logic [7:0] back_loc;
   logic [1:0] top_dir;
   logic       empty;
   logic       full;
   logic       ovf;
   logic       rp_start = 1'b0;
   logic [7:0] rp_origin = 8'h00;
   logic [7:0] rp_loc;
   logic       rp_valid;
   logic       rp_ready = 1'b0;
   logic       rp_last;
   logic       busy;
`ifdef MOVE_STACK_BOUNDS_CHK_EN
   logic       bnd_err;
`endif

   int nVec = 0;
   int nErr = 0;

   logic [1:0] pathQ[$];
   bit mOvf = 1'b0;
   bit mBnd = 1'b0;

   always #5 clk = ~clk;

   move_stack dut (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_dir  (push_dir),
      .pop       (pop),
      .cur_loc   (cur_loc),
      .back_loc  (back_loc),
      .top_dir   (top_dir),
      .empty     (empty),
      .full      (full),
      .ovf       (ovf),
      .rp_start  (rp_start),
      .rp_origin (rp_origin),
      .rp_loc    (rp_loc),
      .rp_valid  (rp_valid),
      .rp_ready  (rp_ready),
      .rp_last   (rp_last),
      .busy      (busy)
`ifdef MOVE_STACK_BOUNDS_CHK_EN
      ,
      .bnd_err   (bnd_err)
`endif
   );

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      nVec++;
      if (obs !== exp) begin
         nErr++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // location after taking move d from l, bit 8 = coordinate wrapped
   function automatic logic [8:0] fwd(logic [7:0] l, logic [1:0] d);
      int x = int'(l[7:4]);
      int y = int'(l[3:0]);
      bit w;
      case (d)
         2'b00:   begin w = (y == 0);  y = (y + 15) % 16; end
         2'b01:   begin w = (x == 15); x = (x + 1) % 16;  end
         2'b10:   begin w = (x == 0);  x = (x + 15) % 16; end
         default: begin w = (y == 15); y = (y + 1) % 16;  end
      endcase
      return {w, 4'(x), 4'(y)};
   endfunction

   // location l was reached from, by move d
   function automatic logic [7:0] undo(logic [7:0] l, logic [1:0] d);
      int x = int'(l[7:4]);
      int y = int'(l[3:0]);
      case (d)
         2'b00:   y = (y + 1) % 16;
         2'b01:   x = (x + 15) % 16;
         2'b10:   x = (x + 1) % 16;
         default: y = (y + 15) % 16;
      endcase
      return {4'(x), 4'(y)};
   endfunction

   task automatic modelOp(bit pu, bit po, logic [1:0] d);
      logic [8:0] f;
      bit wr;
      f  = fwd(cur_loc, d);
      wr = f[8];
`ifndef MOVE_STACK_BOUNDS_CHK_EN
      wr = 1'b0;
`endif
      if (pu && po && pathQ.size() > 0) begin
         if (wr) mBnd = 1'b1;
         else pathQ[pathQ.size()-1] = d;
      end else if (pu) begin
         if (pathQ.size() == 256) mOvf = 1'b1;
         else if (wr) mBnd = 1'b1;
         else pathQ.push_back(d);
      end else if (po) begin
         if (pathQ.size() > 0) void'(pathQ.pop_back());
      end
   endtask

   task automatic doOp(bit pu, bit po, logic [1:0] d);
      push     = pu;
      pop      = po;
      push_dir = d;
      tick();
      push = 1'b0;
      pop  = 1'b0;
      modelOp(pu, po, d);
   endtask

   task automatic checkStack();
      int n = pathQ.size();
      logic [1:0] t = 2'b00;
      logic [7:0] b = 8'h00;
      if (n > 0) begin
         t = pathQ[n-1];
         b = undo(cur_loc, t);
      end
      check("empty", empty, n == 0);
      check("full", full, n == 256);
      check("ovf", ovf, mOvf);
      check("top_dir", top_dir, t);
      check("back_loc", back_loc, b);
      check("busy_idle", busy, 0);
`ifdef MOVE_STACK_BOUNDS_CHK_EN
      check("bnd_err", bnd_err, mBnd);
`endif
   endtask

   task automatic runReplay(logic [7:0] origin, int mode, bit pushDuring);
      logic [7:0] expQ[$];
      logic [7:0] l = origin;
      logic [8:0] f;
      int k = 0;
      int cyc = 0;
      expQ.push_back(l);
      foreach (pathQ[i]) begin
         f = fwd(l, pathQ[i]);
`ifdef MOVE_STACK_BOUNDS_CHK_EN
         if (f[8]) mBnd = 1'b1;
`endif
         l = f[7:0];
         expQ.push_back(l);
      end
      rp_origin = origin;
      rp_start  = 1'b1;
      tick();
      rp_start = 1'b0;
      push     = pushDuring;
      push_dir = 2'b10;
      while (k < expQ.size() && cyc < 4000) begin
         case (mode)
            0:       rp_ready = 1'b1;
            1:       rp_ready = (cyc % 2 == 0);
            default: rp_ready = 1'($urandom_range(0, 1));
         endcase
         #1;
         check("rp_valid", rp_valid, 1);
         check("rp_loc", rp_loc, expQ[k]);
         check("rp_last", rp_last, k == expQ.size() - 1);
         check("busy_run", busy, 1);
         if (rp_ready) k++;
         cyc++;
         tick();
      end
      push     = 1'b0;
      rp_ready = 1'b0;
      if (k < expQ.size()) check("rp_timeout", k, expQ.size());
      check("rp_valid_end", rp_valid, 0);
      check("rp_last_end", rp_last, 0);
      check("busy_end", busy, 0);
   endtask

   task automatic drain();
      while (pathQ.size() > 0) doOp(1'b0, 1'b1, 2'b00);
   endtask

   initial begin
      int r;
      #2 rst = 1'b0;
      #1;
      check("rst_rp_valid", rp_valid, 0);
      check("rst_rp_last", rp_last, 0);
      check("rst_rp_loc", rp_loc, 0);
      checkStack();
      @(negedge clk) rst = 1'b1;
      tick();

      cur_loc = 8'h33;
      doOp(1'b1, 1'b0, 2'b01);
      doOp(1'b1, 1'b0, 2'b01);
      doOp(1'b1, 1'b0, 2'b11);
      check("t1_top", top_dir, 2'b11);
      cur_loc = 8'h54;
      #1;
      check("t1_back", back_loc, 8'h53);
      checkStack();

      repeat (3) doOp(1'b0, 1'b1, 2'b00);
      check("t2_empty", empty, 1);
      check("t2_back", back_loc, 8'h00);
      doOp(1'b0, 1'b1, 2'b00);
      check("t2_ovf", ovf, 0);
      checkStack();

      cur_loc = 8'h77;
      repeat (256) doOp(1'b1, 1'b0, 2'($urandom_range(0, 3)));
      check("t3_full", full, 1);
      checkStack();
      doOp(1'b1, 1'b0, 2'b10);
      check("t3_ovf", ovf, 1);
      checkStack();
      doOp(1'b1, 1'b1, ~top_dir);
      checkStack();

      repeat (400) begin
         cur_loc = 8'($urandom);
         r = $urandom_range(0, 9);
         doOp(r < 4 || r >= 8, r >= 4, 2'($urandom_range(0, 3)));
         checkStack();
      end

      drain();
      cur_loc = 8'h77;
      doOp(1'b1, 1'b0, 2'b01);
      doOp(1'b1, 1'b0, 2'b11);
      doOp(1'b1, 1'b0, 2'b10);
      runReplay(8'h00, 0, 1'b0);
      checkStack();

      runReplay(8'h00, 1, 1'b1);
      checkStack();

      drain();
      runReplay(8'($urandom), 2, 1'b0);
      checkStack();

      repeat (6) begin
         drain();
         cur_loc = 8'h77;
         repeat ($urandom_range(0, 20)) doOp(1'b1, 1'b0, 2'($urandom_range(0, 3)));
         runReplay(8'($urandom), 2, 1'($urandom_range(0, 1)));
         checkStack();
      end

      drain();
      cur_loc = 8'h77;
      repeat (5) doOp(1'b1, 1'b0, 2'($urandom_range(0, 3)));
      rp_origin = 8'h88;
      rp_start  = 1'b1;
      tick();
      rp_start = 1'b0;
      rp_ready = 1'b1;
      tick();
      tick();
      check("t6_pre_valid", rp_valid, 1);
      rst = 1'b0;
      #1;
      check("t6_rp_valid", rp_valid, 0);
      check("t6_rp_last", rp_last, 0);
      check("t6_rp_loc", rp_loc, 0);
      check("t6_empty", empty, 1);
      check("t6_busy", busy, 0);
      check("t6_ovf", ovf, 0);
      pathQ.delete();
      mOvf     = 1'b0;
      mBnd     = 1'b0;
      rp_ready = 1'b0;
      @(negedge clk) rst = 1'b1;
      tick();
      checkStack();

`ifdef MOVE_STACK_BOUNDS_CHK_EN
      cur_loc = 8'h00;
      doOp(1'b1, 1'b0, 2'b00);
      check("t6_bnd_err", bnd_err, 1);
      check("t6_bnd_empty", empty, 1);
      checkStack();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

endmodule
